// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex font, scan states.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high font, element 0 is hex 0; bit SEG_A..SEG_G lights a..g
    localparam logic [15:0][SEG_W-1:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        SCAN_DEAD = 1'b0,
        SCAN_SHOW = 1'b1
    } scan_state_e;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
        return HEX_FONT[hex];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered value load and
// dead-time gaps between digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic [SEG_W-1:0]        seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic                  POL       = (ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{POL}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF    = {NUM_DIGITS{POL}};

    scan_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]        active_q, active_d;
    logic [NUM_DIGITS-1:0][3:0]        pending_q, pending_d;
    logic                              pending_valid_q, pending_valid_d;
    logic                              load_ready_q;
    logic [SEG_W-1:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]             en_q, en_d;
    logic                              frame_done_q, frame_done_d;

    logic                              xfer_c;
    logic [NUM_DIGITS-1:0]             lz_blank_c;
    logic                              zero_run_c;
    logic                              blank_c;
    logic [SEG_W-1:0]                  font_c;

    assign load_ready = load_ready_q;
    assign seg_out    = seg_q;
    assign digit_en   = en_q;
    assign frame_done = frame_done_q;

    assign xfer_c = load_valid & load_ready_q;

    // Scan sequencing: DEAD gap then SHOW slot per digit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        unique case (state_q)
            SCAN_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = SCAN_SHOW;
                    cnt_d   = '0;
                end
            end
            SCAN_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = SCAN_DEAD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = SCAN_DEAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer; frame_done_q marks the current cycle as frame end
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (frame_done_q) begin
            if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end else if (xfer_c) begin
                active_d = load_value;
            end
        end else if (xfer_c) begin
            pending_d       = load_value;
            pending_valid_d = 1'b1;
        end
    end

    // Leading-zero run: digit i is suppressible when it and all above are zero
    always_comb begin
        lz_blank_c = '0;
        zero_run_c = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_c    = zero_run_c & (active_q[i] == 4'h0);
            lz_blank_c[i] = zero_run_c & (i != 0);
        end
    end

    seg7_decode u_decode (
        .hex_i   (active_q[idx_d]),
        .seg_c_o (font_c)
    );

    // Output image for the state entered on the coming edge
    always_comb begin
        seg_d        = SEG_OFF;
        en_d         = EN_OFF;
        blank_c      = blank_mask[idx_d] | (lz_suppress & lz_blank_c[idx_d]);
        frame_done_d = (state_d == SCAN_SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
        if ((state_d == SCAN_SHOW) && !blank_c) begin
            seg_d = font_c ^ SEG_OFF;
            en_d  = (NUM_DIGITS'(1) << idx_d) ^ EN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= SCAN_DEAD;
            cnt_q           <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            load_ready_q    <= 1'b1;
            seg_q           <= SEG_OFF;
            en_q            <= EN_OFF;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            load_ready_q    <= ~pending_valid_d;
            seg_q           <= seg_d;
            en_q            <= en_d;
            frame_done_q    <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model feeding a
// per-cycle expectation queue, plus directed display checks.
module tb_seg7_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned DIV   = 4;
    localparam int unsigned DEAD  = 1;
    localparam int unsigned SLOT  = DIV + DEAD;
    localparam int unsigned FRAME = ND * SLOT;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] en;
        logic       fd;
        logic       rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int err_cnt = 0;
    int chk_cnt = 0;

    exp_t        exp_q[$];
    int          m_t = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 1'b0;
    bit          blank_mon = 1'b0;
    bit          saw_1011 = 1'b0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (DIV),
        .DEAD_CYCLES (DEAD),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .seg_out     (seg_out),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Active-low font written out as the segment patterns of each glyph
    function automatic logic [6:0] font_al(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'b1000000;  4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;  4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;  4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;  4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;  4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;  4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;  4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;  default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    // Reference model: m_t is the position of the current cycle within the frame
    always @(posedge clk) begin
        exp_t e;
        int   pos;
        int   slot;
        bit   blank;
        if (reset) begin
            m_t  = 0;
            m_act = '0;
            m_pv = 1'b0;
        end else begin
            if (m_t == FRAME - 1) begin
                if (m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end else if (load_valid) begin
                    m_act = load_value;
                end
            end else if (load_valid && !m_pv) begin
                m_pend = load_value;
                m_pv   = 1'b1;
            end
            m_t = (m_t + 1) % FRAME;
        end
        pos  = m_t % SLOT;
        slot = m_t / SLOT;
        e.seg = 7'h7F;
        e.en  = 4'hF;
        if (pos >= DEAD) begin
            blank = blank_mask[slot] || (lz_suppress && slot != 0 && (m_act >> (slot * 4)) == 16'h0);
            if (!blank) begin
                e.seg = font_al(m_act[slot*4 +: 4]);
                e.en  = ~(4'b0001 << slot);
            end
        end
        e.fd  = (m_t == FRAME - 1);
        e.rdy = !m_pv;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("seg_out", 32'(seg_out), 32'(e.seg));
            check("digit_en", 32'(digit_en), 32'(e.en));
            check("frame_done", 32'(frame_done), 32'(e.fd));
            check("load_ready", 32'(load_ready), 32'(e.rdy));
        end
        if (blank_mon && digit_en == 4'b1011) saw_1011 = 1'b1;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_t(input int target);
        bit hit = 1'b0;
        for (int k = 0; k < 4 * FRAME && !hit; k++) begin
            if (m_t == target) hit = 1'b1;
            else tick(1);
        end
        check("wait_t", 32'(hit), 32'd1);
    endtask

    task automatic send(input logic [15:0] v);
        bit done = 1'b0;
        load_value = v;
        load_valid = 1'b1;
        for (int k = 0; k < 4 * FRAME && !done; k++) begin
            done = load_ready;
            tick(1);
        end
        load_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic probe(input string tag, input int t, input logic [6:0] seg, input logic [3:0] en);
        wait_t(t);
        @(negedge clk);
        check({tag, "_seg"}, 32'(seg_out), 32'(seg));
        check({tag, "_en"}, 32'(digit_en), 32'(en));
        tick(1);
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_value  = '0;
        blank_mask  = '0;
        lz_suppress = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_en", 32'(digit_en), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_rdy", 32'(load_ready), 32'd1);
        check("rst_fd", 32'(frame_done), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Initial value 0000 then 1234 shown from the next frame
        probe("first_show", 1, 7'b1000000, 4'b1110);
        wait_t(6);
        send(16'h1234);
        probe("d0_four", 1, 7'b0011001, 4'b1110);
        probe("d3_one", 16, 7'b1111001, 4'b0111);

        // Leading-zero suppression
        lz_suppress = 1'b1;
        send(16'h0050);
        tick(2 * FRAME);
        probe("lz_d2", 11, 7'h7F, 4'hF);
        probe("lz_d1", 6, 7'b0010010, 4'b1101);
        probe("lz_d0", 1, 7'b1000000, 4'b1110);
        send(16'h0000);
        tick(2 * FRAME);
        probe("lz_zero_d1", 6, 7'h7F, 4'hF);
        probe("lz_zero_d0", 1, 7'b1000000, 4'b1110);
        lz_suppress = 1'b0;

        // Bypass load in the frame-end cycle with the pending buffer empty
        tick(FRAME);
        wait_t(FRAME - 1);
        load_value = 16'hBEEF;
        load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        probe("bypass_d0", 1, 7'b0001110, 4'b1110);
        probe("bypass_d3", 16, 7'b0000011, 4'b0111);

        // Masked digit 2 stays dark for two frames
        wait_t(0);
        blank_mask = 4'b0100;
        blank_mon  = 1'b1;
        tick(2 * FRAME);
        blank_mon  = 1'b0;
        blank_mask = 4'b0000;
        check("mask_no_d2", 32'(saw_1011), 32'd0);

        // Reset mid-frame discards both active and pending values
        wait_t(3);
        send(16'h5678);
        wait_t(2 * SLOT + DEAD + 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_en", 32'(digit_en), 32'hF);
        check("mid_rst_seg", 32'(seg_out), 32'h7F);
        check("mid_rst_rdy", 32'(load_ready), 32'd1);
        probe("post_rst_d0", 1, 7'b1000000, 4'b1110);
        probe("post_rst_d3", 16, 7'b1000000, 4'b0111);
        tick(FRAME);
        probe("post_rst_f2", 1, 7'b1000000, 4'b1110);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
